// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU codes,
// state encodings, datapath select codes, trap causes and the control word.
package mc_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_add   = 4'b0010;
   localparam logic [3:0] ALU_sub   = 4'b0110;
   localparam logic [3:0] ALU_undef = 4'b1111;

   typedef enum logic [3:0] {
      MC_S_RESET    = 4'd0,
      MC_S_FETCH    = 4'd1,
      MC_S_DECODE   = 4'd2,
      MC_S_MEMADR   = 4'd3,
      MC_S_MEMRD    = 4'd4,
      MC_S_MEMWB    = 4'd5,
      MC_S_MEMWR    = 4'd6,
      MC_S_EXEC     = 4'd7,
      MC_S_ALUWB    = 4'd8,
      MC_S_IMMEX    = 4'd9,
      MC_S_IMMWB    = 4'd10,
      MC_S_BRANCH   = 4'd11,
      MC_S_JUMP     = 4'd12,
      MC_S_JAL_LINK = 4'd13,
      MC_S_TRAP     = 4'd15
   } mc_state_e;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] TRAP_NONE    = 2'b00;
   localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
   localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

   // fetch and retire_rdy mark outputs that are qualified by mem_ready
   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       invertzero;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [3:0] aluop;
      logic       rtype;
      logic       retire;
      logic       retire_rdy;
      logic       fetch;
      logic       trap;
`ifdef MC_JAL_EN
      logic       link;
`endif
   } mc_ctrl_t;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: down-counter reloaded on clr, decremented on en,
// expire asserted at terminal count (MEM_TIMEOUT-1 waited cycles elapsed).
module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [TMO_W-1:0] LOAD_VAL = TMO_W'(MEM_TIMEOUT - 1);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = LOAD_VAL;
      else if (en && (cnt_q != '0))
         cnt_d = cnt_q - TMO_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= LOAD_VAL;
      else
         cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM (Moore, registered control word).
// Define MC_JAL_EN to add the JAL_LINK state and the link output.
//
//  state    | meaning
//  RESET    | post-reset idle cycle, all outputs low
//  FETCH    | read instruction, PC+4; waits on mem_ready
//  DECODE   | precompute branch target, dispatch on opcode
//  MEMADR   | compute load/store address
//  MEMRD    | load data read; waits on mem_ready
//  MEMWB    | write loaded data to rt, retire
//  MEMWR    | store write; waits on mem_ready, retires on it
//  EXEC     | R-type ALU op (funct decoded downstream)
//  ALUWB    | write ALU result to rd, retire
//  IMMEX    | ADDI/ORI ALU op with immediate
//  IMMWB    | write ALU result to rt, retire
//  BRANCH   | BEQ/BNE compare and conditional PC load, retire
//  JUMP     | J target load, retire
//  JAL_LINK | JAL target load plus $31 link, retire (MC_JAL_EN only)
//  TRAP     | sticky fault, left only by reset
module mc_control
   import mc_control_pkg::*;
#(
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               pcwrite,
   output logic               pcwritecond,
   output logic               invertzero,
   output logic               iord,
   output logic               memread,
   output logic               memwrite,
   output logic               irwrite,
   output logic               memtoreg,
   output logic               regdst,
   output logic               regwrite,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [ALUOP_W-1:0] aluop,
   output logic               rtype,
   output logic               retire,
   output logic               trap,
   output logic [1:0]         trap_cause,
`ifdef MC_JAL_EN
   output logic               link,
`endif
   output logic [3:0]         state
);

   mc_state_e  state_q, state_d;
   mc_ctrl_t   ctrl_q, ctrl_d;
   logic [1:0] cause_q, cause_d;
   logic       waiting, tmo_en, tmo_expire;

   assign waiting = (state_q == MC_S_FETCH) || (state_q == MC_S_MEMRD) ||
                    (state_q == MC_S_MEMWR);
   assign tmo_en  = waiting && !mem_ready;

   mc_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TMO_W       (TMO_W)
   ) u_wait_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (!tmo_en),
      .en     (tmo_en),
      .expire (tmo_expire)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         MC_S_RESET:  state_d = MC_S_FETCH;
         MC_S_FETCH: begin
            if (mem_ready)
               state_d = MC_S_DECODE;
            else if (tmo_expire) begin
               state_d = MC_S_TRAP;
               cause_d = TRAP_TIMEOUT;
            end
         end
         MC_S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:    state_d = MC_S_MEMADR;
               OP_RTYPE:        state_d = MC_S_EXEC;
               OP_ADDI, OP_ORI: state_d = MC_S_IMMEX;
               OP_BEQ, OP_BNE:  state_d = MC_S_BRANCH;
               OP_J:            state_d = MC_S_JUMP;
`ifdef MC_JAL_EN
               OP_JAL:          state_d = MC_S_JAL_LINK;
`endif
               default: begin
                  state_d = MC_S_TRAP;
                  cause_d = TRAP_ILLEGAL;
               end
            endcase
         end
         MC_S_MEMADR: begin
            if (opcode == OP_LW)
               state_d = MC_S_MEMRD;
            else if (opcode == OP_SW)
               state_d = MC_S_MEMWR;
            else begin
               state_d = MC_S_TRAP;
               cause_d = TRAP_ILLEGAL;
            end
         end
         MC_S_MEMRD, MC_S_MEMWR: begin
            if (mem_ready)
               state_d = (state_q == MC_S_MEMRD) ? MC_S_MEMWB : MC_S_FETCH;
            else if (tmo_expire) begin
               state_d = MC_S_TRAP;
               cause_d = TRAP_TIMEOUT;
            end
         end
         MC_S_EXEC:   state_d = MC_S_ALUWB;
         MC_S_IMMEX:  state_d = MC_S_IMMWB;
         MC_S_MEMWB, MC_S_ALUWB, MC_S_IMMWB,
         MC_S_BRANCH, MC_S_JUMP: state_d = MC_S_FETCH;
`ifdef MC_JAL_EN
         MC_S_JAL_LINK: state_d = MC_S_FETCH;
`endif
         MC_S_TRAP:   state_d = MC_S_TRAP;
         default: begin
            state_d = MC_S_TRAP;
            cause_d = TRAP_ILLEGAL;
         end
      endcase
   end

   // control word is decoded from the next state so outputs leave a flop
   always_comb begin
      ctrl_d = '0;
      if ((state_d != MC_S_RESET) && (state_d != MC_S_TRAP))
         ctrl_d.aluop = ALU_undef;
      case (state_d)
         MC_S_FETCH: begin
            ctrl_d.memread = 1'b1;
            ctrl_d.alusrcb = SRCB_FOUR;
            ctrl_d.aluop   = ALU_add;
            ctrl_d.pcsrc   = PCSRC_ALU;
            ctrl_d.fetch   = 1'b1;
         end
         MC_S_DECODE: begin
            ctrl_d.alusrcb = SRCB_IMMSH;
            ctrl_d.aluop   = ALU_add;
         end
         MC_S_MEMADR: begin
            ctrl_d.alusrca = 1'b1;
            ctrl_d.alusrcb = SRCB_IMM;
            ctrl_d.aluop   = ALU_add;
         end
         MC_S_MEMRD: begin
            ctrl_d.memread = 1'b1;
            ctrl_d.iord    = 1'b1;
         end
         MC_S_MEMWB: begin
            ctrl_d.regwrite = 1'b1;
            ctrl_d.memtoreg = 1'b1;
            ctrl_d.retire   = 1'b1;
         end
         MC_S_MEMWR: begin
            ctrl_d.memwrite   = 1'b1;
            ctrl_d.iord       = 1'b1;
            ctrl_d.retire_rdy = 1'b1;
         end
         MC_S_EXEC: begin
            ctrl_d.alusrca = 1'b1;
            ctrl_d.alusrcb = SRCB_REGB;
            ctrl_d.rtype   = 1'b1;
         end
         MC_S_ALUWB: begin
            ctrl_d.regdst   = 1'b1;
            ctrl_d.regwrite = 1'b1;
            ctrl_d.retire   = 1'b1;
         end
         MC_S_IMMEX: begin
            ctrl_d.alusrca = 1'b1;
            ctrl_d.alusrcb = SRCB_IMM;
            ctrl_d.aluop   = (opcode == OP_ORI) ? ALU_OR : ALU_add;
         end
         MC_S_IMMWB: begin
            ctrl_d.regwrite = 1'b1;
            ctrl_d.retire   = 1'b1;
         end
         MC_S_BRANCH: begin
            ctrl_d.alusrca     = 1'b1;
            ctrl_d.alusrcb     = SRCB_REGB;
            ctrl_d.aluop       = ALU_sub;
            ctrl_d.pcwritecond = 1'b1;
            ctrl_d.pcsrc       = PCSRC_ALUOUT;
            ctrl_d.invertzero  = (opcode == OP_BNE);
            ctrl_d.retire      = 1'b1;
         end
         MC_S_JUMP: begin
            ctrl_d.pcwrite = 1'b1;
            ctrl_d.pcsrc   = PCSRC_JUMP;
            ctrl_d.retire  = 1'b1;
         end
`ifdef MC_JAL_EN
         MC_S_JAL_LINK: begin
            ctrl_d.pcwrite  = 1'b1;
            ctrl_d.pcsrc    = PCSRC_JUMP;
            ctrl_d.regwrite = 1'b1;
            ctrl_d.link     = 1'b1;
            ctrl_d.retire   = 1'b1;
         end
`endif
         MC_S_TRAP:  ctrl_d.trap = 1'b1;
         default:    ctrl_d.trap = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MC_S_RESET;
         cause_q <= TRAP_NONE;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign pcwrite     = ctrl_q.pcwrite | (ctrl_q.fetch & mem_ready);
   assign irwrite     = ctrl_q.fetch & mem_ready;
   assign retire      = ctrl_q.retire | (ctrl_q.retire_rdy & mem_ready);
   assign pcwritecond = ctrl_q.pcwritecond;
   assign invertzero  = ctrl_q.invertzero;
   assign iord        = ctrl_q.iord;
   assign memread     = ctrl_q.memread;
   assign memwrite    = ctrl_q.memwrite;
   assign memtoreg    = ctrl_q.memtoreg;
   assign regdst      = ctrl_q.regdst;
   assign regwrite    = ctrl_q.regwrite;
   assign alusrca     = ctrl_q.alusrca;
   assign alusrcb     = ctrl_q.alusrcb;
   assign pcsrc       = ctrl_q.pcsrc;
   assign aluop       = ALUOP_W'(ctrl_q.aluop);
   assign rtype       = ctrl_q.rtype;
   assign trap        = ctrl_q.trap;
   assign trap_cause  = cause_q;
   assign state       = state_q;
`ifdef MC_JAL_EN
   assign link        = ctrl_q.link;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control built with MEM_TIMEOUT=4; follows MC_JAL_EN.
module tb_mc_control;
   import mc_control_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pcwrite, pcwritecond, invertzero, iord, memread, memwrite;
   logic       irwrite, memtoreg, regdst, regwrite, alusrca, rtype, retire, trap;
   logic [1:0] alusrcb, pcsrc, trap_cause;
   logic [3:0] aluop, state;
`ifdef MC_JAL_EN
   logic       link;
`endif
   logic [31:0] all_outs;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   mc_control #(
      .ALUOP_W     (4),
      .MEM_TIMEOUT (4),
      .TMO_W       (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .pcwrite     (pcwrite),
      .pcwritecond (pcwritecond),
      .invertzero  (invertzero),
      .iord        (iord),
      .memread     (memread),
      .memwrite    (memwrite),
      .irwrite     (irwrite),
      .memtoreg    (memtoreg),
      .regdst      (regdst),
      .regwrite    (regwrite),
      .alusrca     (alusrca),
      .alusrcb     (alusrcb),
      .pcsrc       (pcsrc),
      .aluop       (aluop),
      .rtype       (rtype),
      .retire      (retire),
      .trap        (trap),
      .trap_cause  (trap_cause),
`ifdef MC_JAL_EN
      .link        (link),
`endif
      .state       (state)
   );

`ifdef MC_JAL_EN
   assign all_outs = 32'({link, pcwrite, pcwritecond, invertzero, iord, memread, memwrite,
                          irwrite, memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc,
                          aluop, rtype, retire, trap, trap_cause, state});
`else
   assign all_outs = 32'({pcwrite, pcwritecond, invertzero, iord, memread, memwrite,
                          irwrite, memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc,
                          aluop, rtype, retire, trap, trap_cause, state});
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic b(input string tag, input logic obs, input logic exp);
      chk(tag, 32'(obs), 32'(exp));
   endtask

   task automatic st(input string tag, input mc_state_e exp);
      chk(tag, 32'(state), 32'(exp));
   endtask

   task automatic step(input logic rdy, input logic [5:0] op);
      @(negedge clk);
      mem_ready = rdy;
      opcode    = op;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      st("arst_state", MC_S_RESET);
      b("arst_retire", retire, 1'b0);
      b("arst_trap", trap, 1'b0);
      chk("arst_cause", 32'(trap_cause), 32'(TRAP_NONE));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      opcode    = OP_LW;
      #12;
      st("rst_hold_state", MC_S_RESET);
      chk("rst_hold_outs", all_outs, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      st("rst_rel_state", MC_S_RESET);
      chk("rst_rel_outs", all_outs, 32'h0);

      // LW, no memory wait
      step(1'b1, OP_LW);
      st("lw_fetch", MC_S_FETCH);
      b("lw_fetch_irwrite", irwrite, 1'b1);
      b("lw_fetch_pcwrite", pcwrite, 1'b1);
      b("lw_fetch_memread", memread, 1'b1);
      b("lw_fetch_iord", iord, 1'b0);
      chk("lw_fetch_srcb", 32'(alusrcb), 32'(SRCB_FOUR));
      chk("lw_fetch_aluop", 32'(aluop), 32'(ALU_add));
      step(1'b1, OP_LW);
      st("lw_decode", MC_S_DECODE);
      chk("lw_decode_srcb", 32'(alusrcb), 32'(SRCB_IMMSH));
      b("lw_decode_regwrite", regwrite, 1'b0);
      b("lw_decode_retire", retire, 1'b0);
      step(1'b1, OP_LW);
      st("lw_memadr", MC_S_MEMADR);
      b("lw_memadr_srca", alusrca, 1'b1);
      chk("lw_memadr_srcb", 32'(alusrcb), 32'(SRCB_IMM));
      step(1'b1, OP_LW);
      st("lw_memrd", MC_S_MEMRD);
      b("lw_memrd_memread", memread, 1'b1);
      b("lw_memrd_iord", iord, 1'b1);
      b("lw_memrd_retire", retire, 1'b0);
      step(1'b1, OP_LW);
      st("lw_memwb", MC_S_MEMWB);
      b("lw_memwb_regwrite", regwrite, 1'b1);
      b("lw_memwb_memtoreg", memtoreg, 1'b1);
      b("lw_memwb_regdst", regdst, 1'b0);
      b("lw_memwb_retire", retire, 1'b1);

      // SW, write completes on the 4th MEMWR cycle (counter at terminal count)
      step(1'b1, OP_SW);
      st("sw_fetch", MC_S_FETCH);
      step(1'b1, OP_SW);
      step(1'b1, OP_SW);
      st("sw_memadr", MC_S_MEMADR);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, OP_SW);
         st("sw_memwr_wait", MC_S_MEMWR);
         b("sw_wait_memwrite", memwrite, 1'b1);
         b("sw_wait_retire", retire, 1'b0);
      end
      step(1'b1, OP_SW);
      st("sw_memwr_done", MC_S_MEMWR);
      b("sw_done_memwrite", memwrite, 1'b1);
      b("sw_done_retire", retire, 1'b1);

      // BNE then BEQ
      step(1'b1, OP_BNE);
      st("bne_fetch", MC_S_FETCH);
      b("sw_no_trap", trap, 1'b0);
      step(1'b1, OP_BNE);
      step(1'b1, OP_BNE);
      st("bne_branch", MC_S_BRANCH);
      b("bne_pcwritecond", pcwritecond, 1'b1);
      b("bne_invertzero", invertzero, 1'b1);
      chk("bne_aluop", 32'(aluop), 32'(ALU_sub));
      chk("bne_pcsrc", 32'(pcsrc), 32'(PCSRC_ALUOUT));
      b("bne_retire", retire, 1'b1);
      step(1'b1, OP_BEQ);
      step(1'b1, OP_BEQ);
      step(1'b1, OP_BEQ);
      st("beq_branch", MC_S_BRANCH);
      b("beq_invertzero", invertzero, 1'b0);
      b("beq_pcwritecond", pcwritecond, 1'b1);

      // ORI
      step(1'b1, OP_ORI);
      step(1'b1, OP_ORI);
      step(1'b1, OP_ORI);
      st("ori_immex", MC_S_IMMEX);
      chk("ori_aluop", 32'(aluop), 32'(ALU_OR));
      chk("ori_srcb", 32'(alusrcb), 32'(SRCB_IMM));
      step(1'b1, OP_ORI);
      st("ori_immwb", MC_S_IMMWB);
      b("ori_regwrite", regwrite, 1'b1);
      b("ori_regdst", regdst, 1'b0);
      b("ori_retire", retire, 1'b1);

      // J
      step(1'b1, OP_J);
      step(1'b1, OP_J);
      step(1'b1, OP_J);
      st("j_jump", MC_S_JUMP);
      b("j_pcwrite", pcwrite, 1'b1);
      chk("j_pcsrc", 32'(pcsrc), 32'(PCSRC_JUMP));
      b("j_retire", retire, 1'b1);

      // R-type fetch completing on the last cycle before timeout
      for (int i = 0; i < 3; i++) begin
         step(1'b0, OP_RTYPE);
         st("hs_fetch_wait", MC_S_FETCH);
         b("hs_wait_irwrite", irwrite, 1'b0);
         b("hs_wait_pcwrite", pcwrite, 1'b0);
      end
      step(1'b1, OP_RTYPE);
      st("hs_fetch_done", MC_S_FETCH);
      b("hs_done_irwrite", irwrite, 1'b1);
      step(1'b1, OP_RTYPE);
      st("hs_decode", MC_S_DECODE);
      b("hs_no_trap", trap, 1'b0);
      step(1'b1, OP_RTYPE);
      st("r_exec", MC_S_EXEC);
      b("r_rtype", rtype, 1'b1);
      chk("r_aluop", 32'(aluop), 32'(ALU_undef));
      step(1'b1, OP_RTYPE);
      st("r_aluwb", MC_S_ALUWB);
      b("r_regdst", regdst, 1'b1);
      b("r_regwrite", regwrite, 1'b1);
      b("r_retire", retire, 1'b1);

      // JAL
      step(1'b1, OP_JAL);
      step(1'b1, OP_JAL);
      step(1'b1, OP_JAL);
`ifdef MC_JAL_EN
      st("jal_link_state", MC_S_JAL_LINK);
      b("jal_link", link, 1'b1);
      b("jal_regwrite", regwrite, 1'b1);
      b("jal_pcwrite", pcwrite, 1'b1);
      chk("jal_pcsrc", 32'(pcsrc), 32'(PCSRC_JUMP));
      b("jal_retire", retire, 1'b1);
`else
      st("jal_trap_state", MC_S_TRAP);
      b("jal_trap", trap, 1'b1);
      chk("jal_cause", 32'(trap_cause), 32'(TRAP_ILLEGAL));
      b("jal_retire", retire, 1'b0);
`endif

      // illegal opcode, sticky trap
      do_reset();
      step(1'b1, 6'h3F);
      step(1'b1, 6'h3F);
      st("ill_decode", MC_S_DECODE);
      step(1'b1, 6'h3F);
      st("ill_trap_state", MC_S_TRAP);
      b("ill_trap", trap, 1'b1);
      chk("ill_cause", 32'(trap_cause), 32'(TRAP_ILLEGAL));
      chk("ill_aluop", 32'(aluop), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, OP_LW);
         st("ill_sticky_state", MC_S_TRAP);
         chk("ill_sticky_cause", 32'(trap_cause), 32'(TRAP_ILLEGAL));
         b("ill_sticky_memread", memread, 1'b0);
      end

      // mid-instruction reset aborts without retire
      do_reset();
      step(1'b1, OP_LW);
      step(1'b1, OP_LW);
      step(1'b1, OP_LW);
      st("abort_memadr", MC_S_MEMADR);
      do_reset();

      // fetch timeout
      for (int i = 0; i < 4; i++) begin
         step(1'b0, OP_LW);
         st("tmo_fetch_wait", MC_S_FETCH);
         b("tmo_wait_irwrite", irwrite, 1'b0);
         b("tmo_wait_pcwrite", pcwrite, 1'b0);
      end
      step(1'b0, OP_LW);
      st("tmo_trap_state", MC_S_TRAP);
      b("tmo_trap", trap, 1'b1);
      chk("tmo_cause", 32'(trap_cause), 32'(TRAP_TIMEOUT));
      b("tmo_pcwrite", pcwrite, 1'b0);

      do_reset();
      step(1'b1, OP_LW);
      st("final_fetch", MC_S_FETCH);
      b("final_no_trap", trap, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
